// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and frame-length constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state and selects the 11-bit frame length.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: counts CLK_DIV clocks per UART bit and flags the last one.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls words from an upstream FIFO and serialises them LSB byte first as 8N1 frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
//
// state  | meaning
// IDLE   | line idle high, waiting for txEnable with data available
// REQ    | one-cycle FIFO read strobe
// LOAD   | capture readData, restart byte index
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the current byte (parity build only)
// STOP   | stop bit (1); next byte, next word or idle
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  txEnable,
    input  logic                  fifoEmpty,
    output logic                  readEnable,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  txd,
    output logic                  busy
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]     byte_idx_q, byte_idx_d;
    logic                  txd_q, txd_d;
    logic                  read_en_q, read_en_d;
    logic                  busy_q, busy_d;
    logic                  baud_clear, baud_en, baud_tick;

    // The counter is parked at 0 through LOAD so START always gets a full bit.
    assign baud_clear = (state_q == ST_LOAD);
    assign baud_en    = !(state_q inside {ST_IDLE, ST_REQ, ST_LOAD});

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (baud_clear),
        .enable (baud_en),
        .tick   (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            ST_IDLE:  if (txEnable && !fifoEmpty) state_d = ST_REQ;
            ST_REQ:   state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d    = readData;
                byte_idx_d = '0;
                bit_idx_d  = '0;
                state_d    = ST_START;
            end
            ST_START: if (baud_tick) begin
                bit_idx_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: if (baud_tick) begin
                if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: if (baud_tick) state_d = ST_STOP;
`endif
            ST_STOP: if (baud_tick) begin
                // txEnable and fifoEmpty only matter at word boundaries
                if (byte_idx_q == BYTE_W'(BYTES - 1)) begin
                    state_d = (txEnable && !fifoEmpty) ? ST_REQ : ST_IDLE;
                end else begin
                    byte_idx_d = byte_idx_q + BYTE_W'(1);
                    shift_d    = shift_q >> 8;
                    state_d    = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        read_en_d = (state_d == ST_REQ);
        busy_d    = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[bit_idx_d];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: txd_d = ^shift_d[7:0];
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            txd_q      <= 1'b1;
            read_en_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            txd_q      <= txd_d;
            read_en_q  <= read_en_d;
            busy_q     <= busy_d;
        end
    end

    assign txd        = txd_q;
    assign readEnable = read_en_q;
    assign busy       = busy_q;

endmodule
